// File: rtl/alu_bist_if.sv
// Bus between the ALU self-test engine, its host (start/status) and the ALU under test.
// Fail-log signals exist only when ALU_BIST_FAIL_LOG_EN is defined.
interface alu_bist_if #(
    parameter int ERR_W = 12
);
    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [2:0]       alu_op;
    logic [3:0]       alu_result;
    logic             alu_carry;
`ifdef ALU_BIST_FAIL_LOG_EN
    logic             fail_vld;
    logic [2:0]       fail_op;
    logic [3:0]       fail_a;
    logic [3:0]       fail_b;
    logic [3:0]       fail_result;
    logic             fail_carry;

    modport master (
        input  start, alu_result, alu_carry,
        output busy, done, pass, err_count, alu_a, alu_b, alu_op,
        output fail_vld, fail_op, fail_a, fail_b, fail_result, fail_carry
    );
    modport slave (
        output start, alu_result, alu_carry,
        input  busy, done, pass, err_count, alu_a, alu_b, alu_op,
        input  fail_vld, fail_op, fail_a, fail_b, fail_result, fail_carry
    );
`else
    modport master (
        input  start, alu_result, alu_carry,
        output busy, done, pass, err_count, alu_a, alu_b, alu_op
    );
    modport slave (
        output start, alu_result, alu_carry,
        input  busy, done, pass, err_count, alu_a, alu_b, alu_op
    );
`endif
endinterface

// File: rtl/alu_bist.sv
// Built-in self-test engine for the 4-bit ALU: sweeps all 2048 (op,a,b) vectors against a golden model.
// Define ALU_BIST_FAIL_LOG_EN to add a capture of the first mismatching vector.
module alu_bist #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 12,
    parameter bit CHECK_CARRY   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    alu_bist_if.master bus
);
    localparam logic [2:0]       S_IDLE    = 3'd0;
    localparam logic [2:0]       S_DRIVE   = 3'd1;
    localparam logic [2:0]       S_SETTLE  = 3'd2;
    localparam logic [2:0]       S_CHECK   = 3'd3;
    localparam logic [2:0]       S_FINISH  = 3'd4;
    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);
    localparam logic [10:0]      LAST_IDX  = 11'h7FF;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    // Returns {carry, result}; SUB carry is the borrow out of the 5-bit subtraction.
    function automatic logic [4:0] golden(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        logic [4:0] v;
        case (op)
            3'd0:    v = {1'b0, a} + {1'b0, b};
            3'd1:    v = {1'b0, a} - {1'b0, b};
            3'd2:    v = {1'b0, a & b};
            3'd3:    v = {1'b0, a | b};
            3'd4:    v = {1'b0, a ^ b};
            3'd5:    v = {1'b0, ~a};
            3'd6:    v = {a[3], a[2:0], 1'b0};
            default: v = {a[0], 1'b0, a[3:1]};
        endcase
        return v;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
        return (x == ERR_MAX) ? x : x + 1'b1;
    endfunction

    logic [2:0]       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic [2:0]       r_alu_op;
    logic [3:0]       r_settle;
    logic [10:0]      r_idx;
    logic [4:0]       w_exp;
    logic             w_mismatch;
`ifdef ALU_BIST_FAIL_LOG_EN
    logic             r_fail_vld;
    logic [2:0]       r_fail_op;
    logic [3:0]       r_fail_a;
    logic [3:0]       r_fail_b;
    logic [3:0]       r_fail_result;
    logic             r_fail_carry;
`endif

    assign w_exp      = golden(r_alu_op, r_alu_a, r_alu_b);
    assign w_mismatch = (bus.alu_result != w_exp[3:0]) ||
                        (CHECK_CARRY && (bus.alu_carry != w_exp[4]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_alu_a  <= 4'd0;
            r_alu_b  <= 4'd0;
            r_alu_op <= 3'd0;
            r_settle <= 4'd0;
            r_idx    <= 11'd0;
`ifdef ALU_BIST_FAIL_LOG_EN
            r_fail_vld    <= 1'b0;
            r_fail_op     <= 3'd0;
            r_fail_a      <= 4'd0;
            r_fail_b      <= 4'd0;
            r_fail_result <= 4'd0;
            r_fail_carry  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is deliberately dropped.
                    if (bus.start && !r_done) begin
                        r_err   <= '0;
                        r_pass  <= 1'b0;
                        r_idx   <= 11'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_DRIVE;
`ifdef ALU_BIST_FAIL_LOG_EN
                        r_fail_vld    <= 1'b0;
                        r_fail_op     <= 3'd0;
                        r_fail_a      <= 4'd0;
                        r_fail_b      <= 4'd0;
                        r_fail_result <= 4'd0;
                        r_fail_carry  <= 1'b0;
`endif
                    end
                end
                S_DRIVE: begin
                    r_alu_op <= r_idx[10:8];
                    r_alu_a  <= r_idx[7:4];
                    r_alu_b  <= r_idx[3:0];
                    r_settle <= SETTLE_LD;
                    r_state  <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_settle <= r_settle - 4'd1;
                    if (r_settle == 4'd1) r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        r_err <= sat_inc(r_err);
`ifdef ALU_BIST_FAIL_LOG_EN
                        if (!r_fail_vld) begin
                            r_fail_vld    <= 1'b1;
                            r_fail_op     <= r_alu_op;
                            r_fail_a      <= r_alu_a;
                            r_fail_b      <= r_alu_b;
                            r_fail_result <= bus.alu_result;
                            r_fail_carry  <= bus.alu_carry;
                        end
`endif
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_idx   <= r_idx + 11'd1;
                        r_state <= S_DRIVE;
                    end
                end
                S_FINISH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (r_err == '0);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_op    = r_alu_op;
`ifdef ALU_BIST_FAIL_LOG_EN
    assign bus.fail_vld    = r_fail_vld;
    assign bus.fail_op     = r_fail_op;
    assign bus.fail_a      = r_fail_a;
    assign bus.fail_b      = r_fail_b;
    assign bus.fail_result = r_fail_result;
    assign bus.fail_carry  = r_fail_carry;
`endif
endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: two instances (carry checked / result only, narrow counter) against
// fault-injecting ALU models, checked every cycle by a behavioural sweep model.
module tb_alu_bist;
    localparam int S_A   = 1;
    localparam int S_B   = 2;
    localparam int EW_A  = 12;
    localparam int EW_B  = 4;
    localparam int PER_A = S_A + 2;
    localparam int PER_B = S_B + 2;
    localparam int N_A   = 2048 * PER_A;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int         fmode  = 0;
    int         f_op   = 0;
    int         f_a    = 0;
    logic [4:0] f_mask = 5'd0;
    int         n_checks = 0;
    int         n_fail   = 0;

    alu_bist_if #(.ERR_W(EW_A)) if_a ();
    alu_bist_if #(.ERR_W(EW_B)) if_b ();

    alu_bist #(.SETTLE_CYCLES(S_A), .ERR_W(EW_A), .CHECK_CARRY(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .bus(if_a));
    alu_bist #(.SETTLE_CYCLES(S_B), .ERR_W(EW_B), .CHECK_CARRY(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .bus(if_b));

    // Reference ALU from plain integer arithmetic: returns {carry, result}.
    function automatic logic [4:0] ref_gold(input int op, input int a, input int b);
        int r, c;
        c = 0;
        case (op)
            0: begin r = (a + b) % 16; c = (a + b) / 16; end
            1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: begin r = (a * 2) % 16; c = a / 8; end
            default: begin r = a / 2; c = a % 2; end
        endcase
        return 5'(c * 16 + r);
    endfunction

    // The ALU the engine is testing, with a selectable fault.
    function automatic logic [4:0] alu_model(input int mode, input int fo, input int fa,
                                             input logic [4:0] fm, input int op, input int a,
                                             input int b);
        logic [4:0] g;
        g = ref_gold(op, a, b);
        case (mode)
            1: if (op == 0) g = 5'(a + b + 1);
            2: g[4] = 1'b0;
            3: g[3:0] = ~g[3:0];
            4: if (op == fo && a == fa) g = g ^ fm;
            default: ;
        endcase
        return g;
    endfunction

    assign {if_a.alu_carry, if_a.alu_result} = alu_model(fmode, f_op, f_a, f_mask,
        int'(if_a.alu_op), int'(if_a.alu_a), int'(if_a.alu_b));
    assign {if_b.alu_carry, if_b.alu_result} = alu_model(fmode, f_op, f_a, f_mask,
        int'(if_b.alu_op), int'(if_b.alu_a), int'(if_b.alu_b));

    function automatic int sat(input int d, input int x);
        int mx;
        mx = (d == 0) ? ((1 << EW_A) - 1) : ((1 << EW_B) - 1);
        return (x > mx) ? mx : x;
    endfunction

    task automatic check(input string nm, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got 0x%0h expected 0x%0h", nm, d, $time, act, exp);
            if (n_fail >= 40) begin
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    endtask

    // Model: cumulative mismatch counts per sweep and first-failure record.
    int   cum [2][2049];
    bit   m_run [2];
    bit   m_done [2];
    bit   m_pass [2];
    int   m_j [2];
    int   m_err [2];
    int   m_vec [2];
`ifdef ALU_BIST_FAIL_LOG_EN
    logic [16:0] fexp [2];
    logic [16:0] m_ff [2];
`endif

    task automatic build_model();
        for (int d = 0; d < 2; d++) begin
            int first;
            first = -1;
            cum[d][0] = 0;
`ifdef ALU_BIST_FAIL_LOG_EN
            fexp[d] = '0;
`endif
            for (int v = 0; v < 2048; v++) begin
                logic [4:0] e, g;
                bit mis;
                e   = ref_gold(v / 256, (v / 16) % 16, v % 16);
                g   = alu_model(fmode, f_op, f_a, f_mask, v / 256, (v / 16) % 16, v % 16);
                mis = (e[3:0] != g[3:0]) || (d == 0 && e[4] != g[4]);
                cum[d][v + 1] = cum[d][v] + (mis ? 1 : 0);
                if (mis && first < 0) begin
                    first = v;
`ifdef ALU_BIST_FAIL_LOG_EN
                    fexp[d] = {1'b1, 3'(v / 256), 4'((v / 16) % 16), 4'(v % 16), g[3:0], g[4]};
`endif
                end
            end
        end
    endtask

    // Model update on each rising edge, then compare every output just after it.
    always @(posedge clk) begin
        int  per, nn, k, v;
        bit  pd, st;
        logic [31:0] act;
        for (int d = 0; d < 2; d++) begin
            per = (d == 0) ? PER_A : PER_B;
            nn  = 2048 * per;
            st  = (d == 0) ? if_a.start : if_b.start;
            if (rst) begin
                m_run[d] = 0; m_done[d] = 0; m_pass[d] = 0; m_j[d] = 0; m_err[d] = 0; m_vec[d] = 0;
`ifdef ALU_BIST_FAIL_LOG_EN
                m_ff[d] = '0;
`endif
            end else begin
                pd = m_done[d];
                m_done[d] = 0;
                if (m_run[d]) begin
                    m_j[d]++;
                    if (m_j[d] == nn + 1) begin
                        m_run[d]  = 0;
                        m_done[d] = 1;
                        m_pass[d] = (m_err[d] == 0);
                    end
                end else if (st && !pd) begin
                    m_run[d] = 1; m_j[d] = 0; m_pass[d] = 0;
                end
                if (m_run[d]) begin
                    k = m_j[d] / per;
                    if (k > 2048) k = 2048;
                    m_err[d] = sat(d, cum[d][k]);
                    if (m_j[d] >= 1) m_vec[d] = (m_j[d] - 1) / per;
`ifdef ALU_BIST_FAIL_LOG_EN
                    m_ff[d] = (cum[d][k] > 0) ? fexp[d] : 17'd0;
`endif
                end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            v = m_vec[d];
            act = (d == 0) ? {29'd0, if_a.busy, if_a.done, if_a.pass}
                           : {29'd0, if_b.busy, if_b.done, if_b.pass};
            check("busy_done_pass", d, act, {29'd0, m_run[d], m_done[d], m_pass[d]});
            act = (d == 0) ? 32'(if_a.err_count) : 32'(if_b.err_count);
            check("err_count", d, act, 32'(m_err[d]));
            act = (d == 0) ? {21'd0, if_a.alu_op, if_a.alu_a, if_a.alu_b}
                           : {21'd0, if_b.alu_op, if_b.alu_a, if_b.alu_b};
            check("alu_vector", d, act, {21'd0, 3'(v / 256), 4'((v / 16) % 16), 4'(v % 16)});
`ifdef ALU_BIST_FAIL_LOG_EN
            act = (d == 0) ? {15'd0, if_a.fail_vld, if_a.fail_op, if_a.fail_a, if_a.fail_b,
                              if_a.fail_result, if_a.fail_carry}
                           : {15'd0, if_b.fail_vld, if_b.fail_op, if_b.fail_a, if_b.fail_b,
                              if_b.fail_result, if_b.fail_carry};
            check("fail_log", d, act, {15'd0, m_ff[d]});
`endif
        end
    end

    task automatic check_reset_values();
        check("rst_ctl", 0, {29'd0, if_a.busy, if_a.done, if_a.pass}, 32'd0);
        check("rst_ctl", 1, {29'd0, if_b.busy, if_b.done, if_b.pass}, 32'd0);
        check("rst_err", 0, 32'(if_a.err_count), 32'd0);
        check("rst_err", 1, 32'(if_b.err_count), 32'd0);
        check("rst_vec", 0, {21'd0, if_a.alu_op, if_a.alu_a, if_a.alu_b}, 32'd0);
        check("rst_vec", 1, {21'd0, if_b.alu_op, if_b.alu_a, if_b.alu_b}, 32'd0);
`ifdef ALU_BIST_FAIL_LOG_EN
        check("rst_fvld", 0, 32'(if_a.fail_vld), 32'd0);
`endif
    endtask

    // One sweep on both engines; optional start re-pulse or reset at a given vector of dut0.
    task automatic run_sweep(input int mode, input int restart_v, input int reset_v,
                             output int cyc_a);
        bit seen_a, seen_b, aborted;
        fmode = mode;
        build_model();
        @(negedge clk);
        if_a.start = 1'b1;
        if_b.start = 1'b1;
        seen_a = 0; seen_b = 0; aborted = 0; cyc_a = -1;
        for (int i = 1; i <= 20000 && !(seen_a && seen_b); i++) begin
            @(negedge clk);
            if_a.start = 1'b0;
            if_b.start = 1'b0;
            if (restart_v >= 0 && i == restart_v * PER_A + 2) begin
                if_a.start = 1'b1;
                if_b.start = 1'b1;
            end
            if (reset_v >= 0 && i == reset_v * PER_A + 3) begin
                rst = 1'b1;
                #1;
                check_reset_values();
                @(negedge clk);
                rst = 1'b0;
                aborted = 1;
                break;
            end
            if (if_a.done && !seen_a) begin
                seen_a = 1; cyc_a = i; if_a.start = 1'b1;
            end
            if (if_b.done && !seen_b) begin
                seen_b = 1; if_b.start = 1'b1;
            end
        end
        @(negedge clk);
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        if (!aborted) check("done_seen", 0, {30'd0, seen_a, seen_b}, 32'd3);
    endtask

    initial begin
        int cyc;
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        check("gold_add", 0, 32'(ref_gold(0, 15, 1)), 32'h10);
        check("gold_sub", 0, 32'(ref_gold(1, 0, 1)), 32'h1F);
        check("gold_shl", 0, 32'(ref_gold(6, 9, 0)), 32'h12);
        check("gold_shr", 0, 32'(ref_gold(7, 9, 0)), 32'h14);
        check("gold_not", 0, 32'(ref_gold(5, 5, 7)), 32'h0A);

        run_sweep(0, -1, -1, cyc);
        check("clean_err", 0, 32'(if_a.err_count), 32'd0);
        check("clean_pass", 0, 32'(if_a.pass), 32'd1);
        check("clean_pass", 1, 32'(if_b.pass), 32'd1);
        check("done_latency", 0, 32'(cyc), 32'(N_A + 2));

        run_sweep(1, -1, -1, cyc);
        check("add_fault_err", 0, 32'(if_a.err_count), 32'd256);
        check("add_fault_pass", 0, 32'(if_a.pass), 32'd0);
        check("add_fault_err", 1, 32'(if_b.err_count), 32'd15);
`ifdef ALU_BIST_FAIL_LOG_EN
        check("add_fault_log", 0, {15'd0, if_a.fail_vld, if_a.fail_op, if_a.fail_a, if_a.fail_b,
              if_a.fail_result, if_a.fail_carry}, {15'd0, 1'b1, 3'd0, 4'd0, 4'd0, 4'd1, 1'b0});
`endif

        run_sweep(2, -1, -1, cyc);
        check("carry_stuck_err", 0, 32'(if_a.err_count), 32'd496);
        check("carry_stuck_err", 1, 32'(if_b.err_count), 32'd0);
        check("carry_stuck_pass", 1, 32'(if_b.pass), 32'd1);

        run_sweep(3, 100, -1, cyc);
        check("broken_err", 0, 32'(if_a.err_count), 32'd2048);
        check("broken_sat", 1, 32'(if_b.err_count), 32'd15);
        check("restart_latency", 0, 32'(cyc), 32'(N_A + 2));

        repeat (2) begin
            f_op   = int'($urandom_range(0, 7));
            f_a    = int'($urandom_range(0, 15));
            f_mask = 5'($urandom_range(1, 31));
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run_sweep(4, -1, -1, cyc);
        end

        run_sweep(0, -1, 500, cyc);
        repeat (3) @(negedge clk);
        run_sweep(0, -1, -1, cyc);
        check("post_reset_pass", 0, 32'(if_a.pass), 32'd1);
        check("post_reset_pass", 1, 32'(if_b.pass), 32'd1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
